// File: rtl/io_bus_arbiter_if.sv
// Shared I/O bus bundle between the two requesters, the arbiter and the peripheral read mux.
// master: requester + peripheral side; slave: the arbiter itself.
interface io_bus_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 16
) ();
   logic          req0;
   logic          req1;
   logic          rd0;
   logic          rd1;
   logic          wr0;
   logic          wr1;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdat0;
   logic [DW-1:0] wdat1;
   logic          ack0;
   logic          ack1;
   logic [DW-1:0] rdat0;
   logic [DW-1:0] rdat1;
   logic          bus_rd;
   logic          bus_wr;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_dout;
   logic [DW-1:0] bus_din;
   logic          busy;
   logic          owner;

   // Handshake: a requester raises req with rd/wr/addr/wdat valid and holds req until
   // its one-cycle ack; everything is latched at grant, so later changes are ignored.
   modport slave (
      input  req0, req1, rd0, rd1, wr0, wr1, addr0, addr1, wdat0, wdat1, bus_din,
      output ack0, ack1, rdat0, rdat1, bus_rd, bus_wr, bus_addr, bus_dout, busy, owner
   );

   modport master (
      output req0, req1, rd0, rd1, wr0, wr1, addr0, addr1, wdat0, wdat1, bus_din,
      input  ack0, ack1, rdat0, rdat1, bus_rd, bus_wr, bus_addr, bus_dout, busy, owner
   );
endinterface

// File: rtl/io_bus_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the peripheral I/O bus:
// one transaction at a time, single-cycle strobe, fixed access wait, registered read data.
module io_bus_arbiter #(
   parameter int AW         = 16,
   parameter int DW         = 16,
   parameter int ACCESS_CYC = 2,
   parameter bit INIT_PRIO  = 1'b0
) (
   input  logic              sys_clk_i,
   input  logic              sys_rst_i,
   io_bus_arbiter_if.slave   bus,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STROBE = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYC - 1);

   state_t        state;
   logic [3:0]    cnt;
   logic          prio;
   logic          lat_rd;

   logic          grant_any;
   logic          grant_sel;
   logic          sel_rd;
   logic          sel_wr;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdat;

   // Contention goes to the priority pointer; a lone request wins outright.
   assign grant_any = bus.req0 | bus.req1;
   assign grant_sel = (bus.req0 & bus.req1) ? prio : bus.req1;
   assign sel_rd    = grant_sel ? bus.rd1   : bus.rd0;
   assign sel_wr    = grant_sel ? bus.wr1   : bus.wr0;
   assign sel_addr  = grant_sel ? bus.addr1 : bus.addr0;
   assign sel_wdat  = grant_sel ? bus.wdat1 : bus.wdat0;

   assign bus.busy  = (state != IDLE);
   assign dbg_state = state;

   always_ff @(posedge sys_clk_i) begin
      if (!sys_rst_i) begin
         state        <= IDLE;
         cnt          <= '0;
         prio         <= INIT_PRIO;
         lat_rd       <= 1'b0;
         bus.owner    <= INIT_PRIO;
         bus.ack0     <= 1'b0;
         bus.ack1     <= 1'b0;
         bus.rdat0    <= '0;
         bus.rdat1    <= '0;
         bus.bus_rd   <= 1'b0;
         bus.bus_wr   <= 1'b0;
         bus.bus_addr <= '0;
         bus.bus_dout <= '0;
      end else begin
         bus.ack0   <= 1'b0;
         bus.ack1   <= 1'b0;
         bus.bus_rd <= 1'b0;
         bus.bus_wr <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_any) begin
                  // Strobes are registered here so they are high exactly during STROBE.
                  bus.owner    <= grant_sel;
                  bus.bus_addr <= sel_addr;
                  bus.bus_dout <= sel_wdat;
                  bus.bus_rd   <= sel_rd & ~sel_wr;
                  bus.bus_wr   <= sel_wr;
                  lat_rd       <= sel_rd & ~sel_wr;
                  state        <= STROBE;
               end
            end
            STROBE: begin
               if (ACCESS_CYC == 1) begin
                  if (lat_rd) begin
                     if (bus.owner) bus.rdat1 <= bus.bus_din;
                     else           bus.rdat0 <= bus.bus_din;
                  end
                  if (bus.owner) bus.ack1 <= 1'b1;
                  else           bus.ack0 <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt   <= CNT_LOAD;
                  state <= WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               // Counter reaching zero on this edge ends the access window.
               if (cnt == 4'd1) begin
                  if (lat_rd) begin
                     if (bus.owner) bus.rdat1 <= bus.bus_din;
                     else           bus.rdat0 <= bus.bus_din;
                  end
                  if (bus.owner) bus.ack1 <= 1'b1;
                  else           bus.ack0 <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               prio  <= ~bus.owner;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   ap_ack_excl: assert property (@(posedge sys_clk_i) !(bus.ack0 && bus.ack1));
   ap_strobe_excl: assert property (@(posedge sys_clk_i) !(bus.bus_rd && bus.bus_wr));

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: ACCESS_CYC=2 instance for most scenarios,
// a second ACCESS_CYC=1 instance for the short-access case.
module tb_io_bus_arbiter;

   localparam logic [15:0] KEY = 16'hA5C3;

   logic        clk;
   logic        rst_n;
   logic [1:0]  dbg_a;
   logic [1:0]  dbg_b;
   logic        din_fix_en;
   logic [15:0] din_fix;
   logic [15:0] shadow0;
   logic [15:0] shadow1;
   logic [16:0] exp_q[$];
   int          checks;
   int          errors;

   io_bus_arbiter_if #(.AW(16), .DW(16)) ifa ();
   io_bus_arbiter_if #(.AW(16), .DW(16)) ifb ();

   io_bus_arbiter #(.AW(16), .DW(16), .ACCESS_CYC(2), .INIT_PRIO(1'b0)) dut_a (
      .sys_clk_i (clk),
      .sys_rst_i (rst_n),
      .bus       (ifa),
      .dbg_state (dbg_a)
   );

   io_bus_arbiter #(.AW(16), .DW(16), .ACCESS_CYC(1), .INIT_PRIO(1'b0)) dut_b (
      .sys_clk_i (clk),
      .sys_rst_i (rst_n),
      .bus       (ifb),
      .dbg_state (dbg_b)
   );

   // Peripheral model: read data derived from the address on the bus.
   assign ifa.bus_din = din_fix_en ? din_fix : (ifa.bus_addr ^ KEY);
   assign ifb.bus_din = ifb.bus_addr ^ KEY;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic push_exp(input bit r, input bit rd, input bit wr, input logic [15:0] a);
      logic [15:0] e;
      if (rd && !wr) e = din_fix_en ? din_fix : (a ^ KEY);
      else           e = r ? shadow1 : shadow0;
      if (r) shadow1 = e;
      else   shadow0 = e;
      exp_q.push_back({r, e});
   endtask

   task automatic start_txn(input bit r, input bit rd, input bit wr,
                            input logic [15:0] a, input logic [15:0] d, input bit push);
      @(posedge clk);
      #1;
      if (r) begin
         ifa.req1 = 1'b1; ifa.rd1 = rd; ifa.wr1 = wr; ifa.addr1 = a; ifa.wdat1 = d;
      end else begin
         ifa.req0 = 1'b1; ifa.rd0 = rd; ifa.wr0 = wr; ifa.addr0 = a; ifa.wdat0 = d;
      end
      if (push) push_exp(r, rd, wr, a);
   endtask

   task automatic wait_ack(input bit r, output int lat);
      bit found;
      found = 1'b0;
      lat   = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if ((r ? ifa.ack1 : ifa.ack0) === 1'b1) begin
            lat   = k;
            found = 1'b1;
            break;
         end
      end
      if (r) ifa.req1 = 1'b0;
      else   ifa.req0 = 1'b0;
      check("ack_seen", {31'd0, found}, 32'd1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n    = 1'b0;
      ifa.req0 = 1'b0;
      ifa.req1 = 1'b0;
      ifb.req0 = 1'b0;
      ifb.req1 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      shadow0 = '0;
      shadow1 = '0;
      check("rst_state",    {30'd0, dbg_a},         32'd0);
      check("rst_busy",     {31'd0, ifa.busy},      32'd0);
      check("rst_owner",    {31'd0, ifa.owner},     32'd0);
      check("rst_acks",     {30'd0, ifa.ack1, ifa.ack0}, 32'd0);
      check("rst_strobes",  {30'd0, ifa.bus_rd, ifa.bus_wr}, 32'd0);
      check("rst_bus_addr", {16'd0, ifa.bus_addr},  32'd0);
      check("rst_bus_dout", {16'd0, ifa.bus_dout},  32'd0);
      check("rst_rdat0",    {16'd0, ifa.rdat0},     32'd0);
      check("rst_rdat1",    {16'd0, ifa.rdat1},     32'd0);
      check("rst_b_busy",   {31'd0, ifb.busy},      32'd0);
      rst_n = 1'b1;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [16:0] e;
      if (rst_n) begin
         if (ifa.ack0 || ifa.ack1) begin
            check("ack_excl", {31'd0, ifa.ack0 & ifa.ack1}, 32'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_ack", {30'd0, ifa.ack1, ifa.ack0}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("ack_owner", {31'd0, ifa.ack1},  {31'd0, e[16]});
               check("owner_out", {31'd0, ifa.owner}, {31'd0, e[16]});
               check("rdat", {16'd0, (ifa.ack1 ? ifa.rdat1 : ifa.rdat0)}, {16'd0, e[15:0]});
            end
         end
         if (ifa.bus_rd || ifa.bus_wr)
            check("strobe_excl", {31'd0, ifa.bus_rd & ifa.bus_wr}, 32'd0);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int          lat;
      logic [15:0] a[2];
      logic [15:0] b[2];
      checks     = 0;
      errors     = 0;
      rst_n      = 1'b0;
      din_fix_en = 1'b0;
      din_fix    = '0;
      shadow0    = '0;
      shadow1    = '0;
      ifa.req0 = 0; ifa.req1 = 0; ifa.rd0 = 0; ifa.rd1 = 0; ifa.wr0 = 0; ifa.wr1 = 0;
      ifa.addr0 = 0; ifa.addr1 = 0; ifa.wdat0 = 0; ifa.wdat1 = 0;
      ifb.req0 = 0; ifb.req1 = 0; ifb.rd0 = 0; ifb.rd1 = 0; ifb.wr0 = 0; ifb.wr1 = 0;
      ifb.addr0 = 0; ifb.addr1 = 0; ifb.wdat0 = 0; ifb.wdat1 = 0;

      do_reset();

      // Single read, fixed peripheral data
      din_fix_en = 1'b1;
      din_fix    = 16'h1234;
      fork
         begin
            start_txn(1'b0, 1'b1, 1'b0, 16'h6702, 16'h0000, 1'b1);
            wait_ack(1'b0, lat);
            check("t1_latency", lat, 32'd3);
         end
         begin
            @(posedge clk);
            @(negedge clk);
            check("t1_rd_c0", {31'd0, ifa.bus_rd}, 32'd0);
            @(negedge clk);
            check("t1_rd_c1", {31'd0, ifa.bus_rd}, 32'd1);
            check("t1_addr",  {16'd0, ifa.bus_addr}, 32'h6702);
            @(negedge clk);
            check("t1_rd_c2", {31'd0, ifa.bus_rd}, 32'd0);
         end
      join
      din_fix_en = 1'b0;
      check("t1_rdat0_hold", {16'd0, ifa.rdat0}, 32'h1234);

      // Contention: alternation 0,1,0,1 from a fresh reset
      do_reset();
      for (int i = 0; i < 2; i++) begin
         a[i] = 16'($urandom_range(0, 65535));
         b[i] = 16'($urandom_range(0, 65535));
      end
      push_exp(1'b0, 1'b1, 1'b0, a[0]);
      push_exp(1'b1, 1'b1, 1'b0, b[0]);
      push_exp(1'b0, 1'b1, 1'b0, a[1]);
      push_exp(1'b1, 1'b1, 1'b0, b[1]);
      fork
         begin
            int l0;
            for (int i = 0; i < 2; i++) begin
               start_txn(1'b0, 1'b1, 1'b0, a[i], 16'h0000, 1'b0);
               wait_ack(1'b0, l0);
            end
         end
         begin
            int l1;
            for (int i = 0; i < 2; i++) begin
               start_txn(1'b1, 1'b1, 1'b0, b[i], 16'h0000, 1'b0);
               wait_ack(1'b1, l1);
            end
         end
      join

      // Write with both qualifiers set: write wins, bus held stable, rdat1 untouched
      fork
         begin
            start_txn(1'b1, 1'b1, 1'b1, 16'h7003, 16'hBEEF, 1'b1);
            wait_ack(1'b1, lat);
         end
         begin
            @(posedge clk);
            @(negedge clk);
            @(negedge clk);
            check("t3_wr",     {31'd0, ifa.bus_wr},   32'd1);
            check("t3_no_rd",  {31'd0, ifa.bus_rd},   32'd0);
            check("t3_addr_s", {16'd0, ifa.bus_addr}, 32'h7003);
            check("t3_dout_s", {16'd0, ifa.bus_dout}, 32'hBEEF);
            for (int k = 0; k < 2; k++) begin
               @(negedge clk);
               check("t3_wr_low", {31'd0, ifa.bus_wr},   32'd0);
               check("t3_addr",   {16'd0, ifa.bus_addr}, 32'h7003);
               check("t3_dout",   {16'd0, ifa.bus_dout}, 32'hBEEF);
            end
            check("t3_ack1", {31'd0, ifa.ack1}, 32'd1);
         end
      join

      // Random single-requester traffic, including null transactions
      for (int i = 0; i < 10; i++) begin
         start_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'b1);
         wait_ack(ifa.req1, lat);
         check("rand_latency", lat, 32'd3);
      end

      // Reset in WAIT aborts the read: no ack, everything back to reset values
      start_txn(1'b0, 1'b1, 1'b0, 16'h1111, 16'h0000, 1'b1);
      wait_ack(1'b0, lat);
      start_txn(1'b0, 1'b1, 1'b0, 16'h2222, 16'h0000, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("t4_in_wait", {30'd0, dbg_a}, 32'd2);
      rst_n    = 1'b0;
      ifa.req0 = 1'b0;
      @(posedge clk);
      #1;
      check("t4_state",   {30'd0, dbg_a},    32'd0);
      check("t4_strobes", {30'd0, ifa.bus_rd, ifa.bus_wr}, 32'd0);
      check("t4_ack0",    {31'd0, ifa.ack0}, 32'd0);
      check("t4_rdat0",   {16'd0, ifa.rdat0}, 32'd0);
      check("t4_owner",   {31'd0, ifa.owner}, 32'd0);
      check("t4_busy",    {31'd0, ifa.busy}, 32'd0);
      shadow0 = '0;
      shadow1 = '0;
      rst_n   = 1'b1;
      repeat (4) @(posedge clk);

      // ACCESS_CYC=1: req dropped and address changed after the grant
      @(posedge clk);
      #1;
      ifb.req0  = 1'b1;
      ifb.rd0   = 1'b1;
      ifb.addr0 = 16'h5A5A;
      @(posedge clk);
      #1;
      ifb.req0  = 1'b0;
      ifb.rd0   = 1'b0;
      ifb.addr0 = 16'hFFFF;
      @(negedge clk);
      check("t5_rd",      {31'd0, ifb.bus_rd},   32'd1);
      check("t5_addr_s",  {16'd0, ifb.bus_addr}, 32'h5A5A);
      check("t5_no_ack",  {31'd0, ifb.ack0},     32'd0);
      @(negedge clk);
      check("t5_ack0",    {31'd0, ifb.ack0},     32'd1);
      check("t5_addr_d",  {16'd0, ifb.bus_addr}, 32'h5A5A);
      check("t5_rdat0",   {16'd0, ifb.rdat0},    {16'd0, 16'h5A5A ^ KEY});
      @(negedge clk);
      check("t5_ack_end", {31'd0, ifb.ack0},     32'd0);
      check("t5_idle",    {31'd0, ifb.busy},     32'd0);

      repeat (4) @(posedge clk);
      check("q_drain", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
